// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx
//  Description : Asynchronous serial receiver. Oversamples the line with a
//                bit timer, centres on the start bit, shifts in N data bits
//                LSB first, checks the stop bit and hands the word to a
//                valid/ready consumer with sticky frame/overrun error flags.
//                Define SERIAL_RX_PARITY_EN to add an even-parity bit between
//                the data and the stop bit, with a sticky parity_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_rx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         sin,
    input  logic         ready,
    input  logic         clr_err,
    output logic [N-1:0] dout,
    output logic         valid,
    output logic         busy,
    output logic         frame_err,
`ifdef SERIAL_RX_PARITY_EN
    output logic         parity_err,
`endif
    output logic         overrun
);

    localparam int c_TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_TW-1:0] c_HALF_LAST = c_TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(N - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    state_t          r_state;
    logic            r_sync1;
    logic            r_s;
    logic [c_TW-1:0] r_timer;
    logic [c_CW-1:0] r_cnt;
    logic [N-1:0]    r_shreg;
    logic            r_busy;
    logic            r_fin;       // one-cycle pulse: a frame's stop bit was just sampled
    logic            r_stop_ok;
    logic [N-1:0]    r_dout;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_par_ok;
    logic            w_good;
    logic [N-1:0]    w_shift_next;

    // New bit enters at the MSB so that after N samples bit 0 sits at the LSB.
    generate
        if (N > 1) begin : g_shift_wide
            assign w_shift_next = {r_s, r_shreg[N-1:1]};
        end else begin : g_shift_one
            assign w_shift_next = r_s;
        end
    endgenerate

`ifdef SERIAL_RX_PARITY_EN
    logic r_par_ok;
    logic r_parity_err;
    assign w_par_ok   = r_par_ok;
    assign parity_err = r_parity_err;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_good = r_fin && r_stop_ok && w_par_ok;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_s     <= 1'b1;
        end else begin
            r_sync1 <= sin;
            r_s     <= r_sync1;
        end
    end

    // Frame sequencer: start detect, mid-bit sampling, data shift, stop check.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_fin     <= 1'b0;
            r_stop_ok <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par_ok  <= 1'b0;
`endif
        end else begin
            r_fin <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_s) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                        r_timer <= '0;
                    end
                end
                ST_START: begin
                    if (r_timer == c_HALF_LAST) begin
                        r_timer <= '0;
                        r_cnt   <= '0;
                        if (r_s) begin
                            // Glitch, not a real start bit.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_timer == c_BIT_LAST) begin
                        r_timer <= '0;
                        r_shreg <= w_shift_next;
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_timer == c_BIT_LAST) begin
                        r_timer  <= '0;
                        r_par_ok <= ((^r_shreg) == r_s);
                        r_state  <= ST_STOP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // Return to IDLE right after the mid-stop sample so a
                    // following start edge is not missed.
                    if (r_timer == c_BIT_LAST) begin
                        r_timer   <= '0;
                        r_stop_ok <= r_s;
                        r_fin     <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Output handshake and sticky error flags; setting events beat clr_err.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dout       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_good && (!r_valid || ready)) begin
                r_dout  <= r_shreg;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            if (r_fin && !r_stop_ok) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end

            if (w_good && r_valid && !ready) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end

`ifdef SERIAL_RX_PARITY_EN
            if (r_fin && !r_par_ok) begin
                r_parity_err <= 1'b1;
            end else if (clr_err) begin
                r_parity_err <= 1'b0;
            end
`endif
        end
    end

    assign dout      = r_dout;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_rx
//  Description : Directed self-checking bench for serial_rx (N=8,
//                CLKS_PER_BIT=16). Honours SERIAL_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx;

    localparam int N   = 8;
    localparam int CPB = 16;
    // Cycles from the first clock edge that sees sin low to the edge that
    // raises valid: 2 sync + half bit + (N+1) bits (+ parity bit) + 1.
`ifdef SERIAL_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + (N + 1) * CPB + CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + (N + 1) * CPB + 1;
`endif

    logic         clock   = 1'b0;
    logic         resetn  = 1'b0;
    logic         sin     = 1'b1;
    logic         ready   = 1'b0;
    logic         clr_err = 1'b0;
    logic [N-1:0] dout;
    logic         valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;
`ifdef SERIAL_RX_PARITY_EN
    logic         parity_err;
    logic         par_flip = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    serial_rx #(.N(N), .CLKS_PER_BIT(CPB)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .sin       (sin),
        .ready     (ready),
        .clr_err   (clr_err),
        .dout      (dout),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    // Drives one frame. The start bit is applied at a falling edge, so the
    // next rising edge (edge 0) is the first to see it; every bit lasts CPB edges.
    task automatic send_frame(input logic [N-1:0] d, input logic stop_bit);
        @(negedge clock); sin = 1'b0;
        repeat (CPB) @(posedge clock);
        for (int i = 0; i < N; i++) begin
            @(negedge clock); sin = d[i];
            repeat (CPB) @(posedge clock);
        end
`ifdef SERIAL_RX_PARITY_EN
        @(negedge clock); sin = (^d) ^ par_flip;
        repeat (CPB) @(posedge clock);
`endif
        @(negedge clock); sin = stop_bit;
        repeat (CPB) @(posedge clock);
        @(negedge clock); sin = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected %h", dout, 8'h00); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`ifdef SERIAL_RX_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
`endif
        @(negedge clock); resetn = 1'b1;
        repeat (4) @(posedge clock);
    endtask

    task automatic test_false_start();
        // Low for edges 0..3: START is entered at edge 2, the mid-start
        // sample at edge 10 sees the line high again.
        @(negedge clock); sin = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_hi: got %b expected 1", busy); end
        @(negedge clock); sin = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_lo: got %b expected 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL false_start_valid: got %b expected 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL false_start_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL false_start_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_basic();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clock);
                repeat (LAT) @(posedge clock);
                #1;
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", valid); end
                @(posedge clock); #1;
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", valid); end
                checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL basic_dout: got %h expected %h", dout, 8'hA5); end
                checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b expected 0", frame_err); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
            end
        join
    endtask

    task automatic test_handshake();
        repeat (3) @(posedge clock); #1;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hs_hold_valid: got %b expected 1", valid); end
        @(negedge clock); ready = 1'b1;
        @(posedge clock); #1; ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hs_consume_valid: got %b expected 0", valid); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL hs_consume_dout: got %h expected %h", dout, 8'hA5); end
    endtask

    task automatic test_frame_err();
        fork
            send_frame(8'h3C, 1'b0);
            begin
                @(negedge clock);
                repeat (LAT) @(posedge clock);
                #1; clr_err = 1'b1;   // collides with the flag-setting edge
                checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_early: got %b expected 0", frame_err); end
                @(posedge clock); #1; clr_err = 1'b0;
                checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set_wins: got %b expected 1", frame_err); end
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", valid); end
                checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL ferr_dout_kept: got %h expected %h", dout, 8'hA5); end
            end
        join
        repeat (2 * CPB) @(posedge clock);
        @(negedge clock); clr_err = 1'b1;
        @(posedge clock); #1; clr_err = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
    endtask

    task automatic test_back_to_back();
        fork
            send_frame(8'h11, 1'b1);
            begin
                @(negedge clock);
                repeat (LAT + 1) @(posedge clock); #1;
                checks++; if (dout !== 8'h11) begin errors++; $display("FAIL b2b_first_dout: got %h expected %h", dout, 8'h11); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_first_overrun: got %b expected 0", overrun); end
            end
        join
        fork
            send_frame(8'h22, 1'b1);
            begin
                @(negedge clock);
                repeat (LAT + 1) @(posedge clock); #1;
                checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
                checks++; if (dout !== 8'h11) begin errors++; $display("FAIL b2b_overrun_dout: got %h expected %h", dout, 8'h11); end
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_overrun_valid: got %b expected 1", valid); end
            end
        join
        @(negedge clock); clr_err = 1'b1;
        @(posedge clock); #1; clr_err = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_clear: got %b expected 0", overrun); end
        fork
            send_frame(8'h22, 1'b1);
            begin
                @(negedge clock);
                repeat (LAT) @(posedge clock);
                #1; ready = 1'b1;   // consume in the very cycle the new word loads
                checks++; if (dout !== 8'h11) begin errors++; $display("FAIL b2b_pre_load_dout: got %h expected %h", dout, 8'h11); end
                @(posedge clock); #1; ready = 1'b0;
                checks++; if (dout !== 8'h22) begin errors++; $display("FAIL b2b_load_dout: got %h expected %h", dout, 8'h22); end
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_load_valid: got %b expected 1", valid); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_load_overrun: got %b expected 0", overrun); end
            end
        join
    endtask

    task automatic test_reset_midframe();
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(negedge clock);
                // Data bit 4 occupies edges 80..95 of the frame.
                repeat (87) @(posedge clock);
                #1;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
                #2; resetn = 1'b0;
                #1;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy: got %b expected 0", busy); end
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", valid); end
                checks++; if (dout !== 8'h00) begin errors++; $display("FAIL mid_async_dout: got %h expected %h", dout, 8'h00); end
                repeat (3) @(posedge clock);
                @(negedge clock); resetn = 1'b1;
            end
        join
        repeat (CPB) @(posedge clock); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_busy: got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_after_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_after_overrun: got %b expected 0", overrun); end
        fork
            send_frame(8'h5A, 1'b1);
            begin
                @(negedge clock);
                repeat (LAT + 1) @(posedge clock); #1;
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: got %b expected 1", valid); end
                checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL post_reset_dout: got %h expected %h", dout, 8'h5A); end
            end
        join
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        @(negedge clock); ready = 1'b1;
        @(posedge clock); #1; ready = 1'b0;
        par_flip = 1'b0;
        fork
            send_frame(8'h07, 1'b1);
            begin
                @(negedge clock);
                repeat (LAT + 1) @(posedge clock); #1;
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL par_good_valid: got %b expected 1", valid); end
                checks++; if (dout !== 8'h07) begin errors++; $display("FAIL par_good_dout: got %h expected %h", dout, 8'h07); end
                checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b expected 0", parity_err); end
            end
        join
        @(negedge clock); ready = 1'b1;
        @(posedge clock); #1; ready = 1'b0;
        par_flip = 1'b1;
        fork
            send_frame(8'h07, 1'b1);
            begin
                @(negedge clock);
                repeat (LAT + 1) @(posedge clock); #1;
                checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b expected 1", parity_err); end
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL par_bad_valid: got %b expected 0", valid); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL par_bad_overrun: got %b expected 0", overrun); end
            end
        join
        par_flip = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_false_start();
        test_basic();
        test_handshake();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter N, default 8, number of data bits per frame (1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (even, >=4).
REQ-003 SHALL have port clock  input  1  rising-edge system clock.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sin  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port ready  input  1  consumer accepts dout when high with valid.
REQ-007 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-008 SHALL have port dout  output  N  last received data word, LSB first on the line.
REQ-009 SHALL have port valid  output  1  dout holds an unconsumed word.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 SHALL have port frame_err  output  1  sticky, stop bit sampled low.
REQ-012 SHALL have port overrun  output  1  sticky, good frame arrived while valid && !ready.
REQ-013 SHALL have port parity_err  output  1  sticky, present only when SERIAL_RX_PARITY_EN is defined.

Function
REQ-014 SHALL pass sin through a 2-flop synchronizer (both flops reset to 1); all FSM decisions use the synchronized value s.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE: s==0 -> START with bit-timer cleared; otherwise stay.
REQ-017 START: after CLKS_PER_BIT/2 cycles sample s; s==1 -> IDLE (false start, no flags); s==0 -> DATA, timer cleared, bit counter 0.
REQ-018 DATA: every CLKS_PER_BIT cycles sample s and shift right into the internal shift register, new bit entering at MSB (Q <= {s, Q[N-1:1]}); after the Nth sample -> PARITY if enabled, else STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles sample s; go to IDLE the following cycle in all cases (no wait for end of stop bit).
REQ-020 Stop sample 0 SHALL set frame_err, discard the word, leave dout/valid unchanged.
REQ-021 Good frame SHALL, one cycle after the stop sample: if !valid or ready, load dout from the shift register and set valid; else set overrun, drop the word, keep dout.
REQ-022 valid SHALL clear on a cycle with valid && ready unless a good-frame load occurs in the same cycle, in which case valid stays 1 and the new word loads.
REQ-023 clr_err SHALL clear all sticky flags; a flag-setting event in the same cycle SHALL win.
REQ-024 Internal shift register SHALL NOT be visible on dout except via the REQ-021 load.
REQ-025 Line-to-valid latency SHALL be 2 (sync) + CLKS_PER_BIT/2 + (N+1)*CLKS_PER_BIT (+CLKS_PER_BIT with parity) + 1 cycles from sin falling edge.

Reset
REQ-026 resetn low SHALL asynchronously force FSM=IDLE, timers/counters=0, shift register=0, dout=0, valid=0, busy=0, all error flags=0, synchronizer=1.
REQ-027 Reset mid-frame SHALL abort the frame; no valid or flag from it after release.

Configuration
REQ-028 With macro SERIAL_RX_PARITY_EN defined: one even-parity bit follows the data; PARITY state samples it after CLKS_PER_BIT cycles, then STOP.
REQ-029 Parity mismatch SHALL set parity_err and discard the word (no load, no overrun) even if the stop bit is good; frame_err also sets if the stop bit is low.
REQ-030 Without the macro: no PARITY state, no parity_err port, frame = start + N data + stop.

Verification (N=8, CLKS_PER_BIT=16)
REQ-031 Frame 0xA5, ready=0 -> valid=1, dout=0xA5 at 2+8+144+1=155 cycles after start edge; frame_err=overrun=0.
REQ-032 sin low for 4 cycles then high -> busy pulses, returns to IDLE, valid=0, no flags.
REQ-033 Frame 0x3C with stop bit 0 -> frame_err=1, valid=0, dout unchanged; clr_err pulse -> frame_err=0.
REQ-034 Frames 0x11 then 0x22, ready=0 -> dout=0x11, valid=1, overrun=1; ready pulse on 0x22's load cycle -> dout=0x22, valid=1, overrun=0.
REQ-035 resetn low at DATA bit 4 of 0xFF, then released -> all outputs 0; next good frame 0x5A received correctly.
REQ-036 SERIAL_RX_PARITY_EN: 0x07 with parity 1 -> dout=0x07 at 171 cycles; with parity 0 -> parity_err=1, valid=0.
